// File: rtl/imem_loader.sv
// imem_loader: byte-wide host port that writes a program into instruction
// memory, verifies a trailing checksum byte and restarts the core from pc=0.
//
// Ports:
//   clk, rst_n      core clock, asynchronous active-low reset
//   ld_mode_i       async; high requests a load session
//   ld_strobe_i     async; a rising edge presents one byte on ld_data_i
//   ld_data_i       byte value, stable while ld_strobe_i is high
//   imem_we/waddr/wdata  one-cycle registered imem write port
//   core_hold       core freezes pc, acc and dmem writes while high
//   core_restart    one-cycle pulse: core resets pc and acc
//   ld_busy         high while loading bytes or waiting for the checksum
//   ld_err          sticky: the last session failed (bad checksum or abort)
module imem_loader #(
    parameter int unsigned IMEM_SZ     = 16,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_mode_i,
    input  logic              ld_strobe_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_hold,
    output logic              core_restart,
    output logic              ld_busy,
    output logic              ld_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_SZ - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHK   = 3'd2,
        S_START = 3'd3,
        S_RUN   = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    // Synchronizer chains for the two asynchronous host controls
    logic [SYNC_STAGES-1:0] mode_sync;
    logic [SYNC_STAGES-1:0] stb_sync;
    logic                   stb_prev;
    logic                   mode_s;
    logic                   stb_rise;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              err_d;
    logic              we_d;
    logic [ADDR_W-1:0] waddr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              hold_d;
    logic              restart_d;
    logic              busy_d;
    logic [DATA_W-1:0] sum_plus_byte;

    assign mode_s        = mode_sync[SYNC_STAGES-1];
    assign stb_rise      = stb_sync[SYNC_STAGES-1] & ~stb_prev;
    assign sum_plus_byte = sum_q + ld_data_i;

    // State register, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_sync    <= '0;
            stb_sync     <= '0;
            stb_prev     <= 1'b0;
            state_q      <= S_IDLE;
            addr_q       <= '0;
            sum_q        <= '0;
            ld_err       <= 1'b0;
            imem_we      <= 1'b0;
            imem_waddr   <= '0;
            imem_wdata   <= '0;
            core_hold    <= 1'b0;
            core_restart <= 1'b0;
            ld_busy      <= 1'b0;
        end else begin
            mode_sync    <= {mode_sync[SYNC_STAGES-2:0], ld_mode_i};
            stb_sync     <= {stb_sync[SYNC_STAGES-2:0], ld_strobe_i};
            stb_prev     <= stb_sync[SYNC_STAGES-1];
            state_q      <= state_d;
            addr_q       <= addr_d;
            sum_q        <= sum_d;
            ld_err       <= err_d;
            imem_we      <= we_d;
            imem_waddr   <= waddr_d;
            imem_wdata   <= wdata_d;
            core_hold    <= hold_d;
            core_restart <= restart_d;
            ld_busy      <= busy_d;
        end
    end

    // Next-state and datapath update; an abort (mode low) beats a strobe
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sum_d   = sum_q;
        err_d   = ld_err;
        we_d    = 1'b0;
        waddr_d = imem_waddr;
        wdata_d = imem_wdata;
        unique case (state_q)
            S_IDLE: begin
                if (mode_s) begin
                    state_d = S_LOAD;
                    addr_d  = '0;
                    sum_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (!mode_s) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else if (stb_rise) begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = ld_data_i;
                    sum_d   = sum_plus_byte;
                    // Address saturates at the last word; no wrap
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_CHK;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            S_CHK: begin
                if (!mode_s) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else if (stb_rise) begin
                    if (sum_plus_byte == '0) begin
                        state_d = S_START;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_START: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (!mode_s) state_d = S_IDLE;
            end
            S_ERR: begin
                if (!mode_s) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies
    // line up with the state they describe
    always_comb begin
        hold_d    = 1'b0;
        restart_d = 1'b0;
        busy_d    = 1'b0;
        unique case (state_d)
            S_IDLE:  hold_d = err_d;
            S_LOAD:  begin hold_d = 1'b1; busy_d = 1'b1; end
            S_CHK:   begin hold_d = 1'b1; busy_d = 1'b1; end
            S_START: begin hold_d = 1'b1; restart_d = 1'b1; end
            S_RUN:   hold_d = 1'b0;
            S_ERR:   hold_d = 1'b1;
            default: hold_d = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: full load, bad checksum, abort, strobe
// glitch / long strobe, strobes while running, and reset mid-load.
module tb_imem_loader;

    logic       clk;
    logic       rst_n;
    logic       ld_mode_i;
    logic       ld_strobe_i;
    logic [7:0] ld_data_i;
    logic       imem_we;
    logic [3:0] imem_waddr;
    logic [7:0] imem_wdata;
    logic       core_hold;
    logic       core_restart;
    logic       ld_busy;
    logic       ld_err;

    imem_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ld_mode_i    (ld_mode_i),
        .ld_strobe_i  (ld_strobe_i),
        .ld_data_i    (ld_data_i),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .core_hold    (core_hold),
        .core_restart (core_restart),
        .ld_busy      (ld_busy),
        .ld_err       (ld_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] prog [16] = '{8'h59, 8'h0F, 8'h19, 8'h1F, 8'h1E, 8'h05, 8'h1F, 8'h0E,
                              8'hF8, 8'h0F, 8'h43, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    // Sum of prog is 0x23A -> 0x3A mod 256; checksum is 0x100 - 0x3A
    localparam logic [7:0] CHK_OK = 8'hC6;

    logic [3:0] wr_addr [$];
    logic [7:0] wr_data [$];
    int         n_restart;

    // Log every write and restart pulse, sampled away from the active edge
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            wr_addr.push_back(imem_waddr);
            wr_data.push_back(imem_wdata);
        end
        if (rst_n && core_restart) n_restart++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        n_restart = 0;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_mode(input logic v);
        @(negedge clk);
        ld_mode_i = v;
        wait_clk(5);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        ld_data_i   = b;
        ld_strobe_i = 1'b1;
        wait_clk(4);
        ld_strobe_i = 1'b0;
        wait_clk(4);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        ld_mode_i   = 1'b0;
        ld_strobe_i = 1'b0;
        ld_data_i   = 8'h00;
        n_restart   = 0;
        wait_clk(3);
        check("rst_we",      32'(imem_we), 0);
        check("rst_hold",    32'(core_hold), 0);
        check("rst_restart", 32'(core_restart), 0);
        check("rst_busy",    32'(ld_busy), 0);
        check("rst_err",     32'(ld_err), 0);
        check("rst_waddr",   32'(imem_waddr), 0);
        rst_n = 1'b1;
        wait_clk(3);

        // 1: good load
        clear_log();
        set_mode(1'b1);
        check("t1_busy", 32'(ld_busy), 1);
        check("t1_hold", 32'(core_hold), 1);
        for (int i = 0; i < 16; i++) send_byte(prog[i]);
        check("t1_busy_chk", 32'(ld_busy), 1);
        send_byte(CHK_OK);
        wait_clk(2);
        check("t1_nwr", 32'(wr_addr.size()), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < wr_addr.size()) begin
                check("t1_addr", 32'(wr_addr[i]), 32'(i));
                check("t1_data", 32'(wr_data[i]), 32'(prog[i]));
            end
        end
        check("t1_restart", 32'(n_restart), 1);
        check("t1_hold_run", 32'(core_hold), 0);
        check("t1_err", 32'(ld_err), 0);
        check("t1_busy_run", 32'(ld_busy), 0);

        // 5: strobes while running are ignored
        clear_log();
        for (int i = 0; i < 3; i++) send_byte(8'hA5);
        check("t5_nwr", 32'(wr_addr.size()), 0);
        check("t5_restart", 32'(n_restart), 0);
        set_mode(1'b0);
        check("t5_idle_hold", 32'(core_hold), 0);
        set_mode(1'b1);
        check("t5_busy", 32'(ld_busy), 1);
        send_byte(prog[0]);
        check("t5_nwr2", 32'(wr_addr.size()), 1);
        if (wr_addr.size() > 0) begin
            check("t5_addr0", 32'(wr_addr[0]), 0);
            check("t5_data0", 32'(wr_data[0]), 32'h59);
        end

        // 2: finish this session with a bad checksum
        for (int i = 1; i < 16; i++) send_byte(prog[i]);
        send_byte(CHK_OK + 8'd1);
        wait_clk(2);
        check("t2_nwr", 32'(wr_addr.size()), 16);
        check("t2_restart", 32'(n_restart), 0);
        check("t2_err", 32'(ld_err), 1);
        check("t2_hold", 32'(core_hold), 1);
        check("t2_busy", 32'(ld_busy), 0);
        set_mode(1'b0);
        check("t2_idle_err", 32'(ld_err), 1);
        check("t2_idle_hold", 32'(core_hold), 1);

        // 3: abort after 5 bytes
        clear_log();
        set_mode(1'b1);
        check("t3_err_clr", 32'(ld_err), 0);
        check("t3_hold", 32'(core_hold), 1);
        for (int i = 0; i < 5; i++) send_byte(prog[i]);
        set_mode(1'b0);
        wait_clk(2);
        check("t3_nwr", 32'(wr_addr.size()), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < wr_addr.size()) check("t3_addr", 32'(wr_addr[i]), 32'(i));
        end
        check("t3_err", 32'(ld_err), 1);
        check("t3_hold_idle", 32'(core_hold), 1);
        check("t3_busy", 32'(ld_busy), 0);
        check("t3_restart", 32'(n_restart), 0);

        // 4: sub-cycle glitch never sampled; 20-clk strobe writes once
        clear_log();
        set_mode(1'b1);
        check("t4_err_clr", 32'(ld_err), 0);
        @(posedge clk);
        ld_data_i = 8'h77;
        #2 ld_strobe_i = 1'b1;
        #4 ld_strobe_i = 1'b0;
        wait_clk(6);
        check("t4_glitch_nwr", 32'(wr_addr.size()), 0);
        @(negedge clk);
        ld_data_i   = 8'h3C;
        ld_strobe_i = 1'b1;
        wait_clk(20);
        ld_strobe_i = 1'b0;
        wait_clk(5);
        check("t4_long_nwr", 32'(wr_addr.size()), 1);
        if (wr_addr.size() > 0) begin
            check("t4_addr", 32'(wr_addr[0]), 0);
            check("t4_data", 32'(wr_data[0]), 32'h3C);
        end
        set_mode(1'b0);

        // 6: reset mid-load at addr 7
        clear_log();
        set_mode(1'b1);
        for (int i = 0; i < 7; i++) send_byte(prog[i]);
        check("t6_nwr", 32'(wr_addr.size()), 7);
        #3 rst_n = 1'b0;
        #1;
        check("t6_rst_we",      32'(imem_we), 0);
        check("t6_rst_hold",    32'(core_hold), 0);
        check("t6_rst_busy",    32'(ld_busy), 0);
        check("t6_rst_err",     32'(ld_err), 0);
        check("t6_rst_restart", 32'(core_restart), 0);
        ld_mode_i = 1'b0;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(5);
        check("t6_idle_busy", 32'(ld_busy), 0);
        check("t6_idle_hold", 32'(core_hold), 0);
        clear_log();
        set_mode(1'b1);
        send_byte(8'hE1);
        check("t6_nwr2", 32'(wr_addr.size()), 1);
        if (wr_addr.size() > 0) begin
            check("t6_addr0", 32'(wr_addr[0]), 0);
            check("t6_data0", 32'(wr_data[0]), 32'hE1);
        end
        set_mode(1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
